// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants: image geometry, input BRAM shape,
// loader state encoding and RGB888 field offsets.
package cnn_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 17;
    localparam int WIDTH  = 480;
    localparam int HEIGHT = 272;
    localparam int DEPTH  = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

endpackage

// File: rtl/rgb888_byte_packer.sv
// Collects R, G, B bytes into one RGB888 word; drops a stale partial pixel
// after TIMEOUT_CYC idle cycles (0 disables the timeout).
module rgb888_byte_packer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic                        accept_i,
    input  logic [7:0]                  byte_i,
    output logic                        pix_valid_o,
    output logic [cnn_pkg::DATA_W-1:0]  pix_word_o
);
    import cnn_pkg::*;

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      r_q, r_d;
    logic [7:0]      g_q, g_d;
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            r_q   <= 8'd0;
            g_q   <= 8'd0;
            to_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
            g_q   <= g_d;
            to_q  <= to_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        g_d   = g_q;
        to_d  = to_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            to_d  = '0;
        end else if (accept_i) begin
            to_d = '0;
            case (cnt_q)
                2'd0:    begin r_d = byte_i; cnt_d = 2'd1; end
                2'd1:    begin g_d = byte_i; cnt_d = 2'd2; end
                default: cnt_d = 2'd0;
            endcase
        end else if (TIMEOUT_CYC != 0 && en_i && cnt_q != 2'd0) begin
            // Idle edge number TIMEOUT_CYC discards the partial pixel.
            if (to_q == TO_LAST) begin
                cnt_d = 2'd0;
                to_d  = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    assign pix_valid_o = accept_i && !clr_i && (cnt_q == 2'd2);

    always_comb begin
        pix_word_o                = '0;
        pix_word_o[R_LSB +: 8]    = r_q;
        pix_word_o[G_LSB +: 8]    = g_q;
        pix_word_o[B_LSB +: 8]    = byte_i;
    end

endmodule

// File: rtl/inbuf_loader.sv
// Input BRAM writer: packs the RGB byte stream into pixels and writes them
// to sequential addresses, flagging frame completion for the window reader.
//
// state | meaning
// IDLE  | after reset, waiting for the first iStart
// LOAD  | accepting bytes, writing one word per completed pixel
// DONE  | frame written, bytes stalled until the next iStart
module inbuf_loader #(
    parameter int DATA_W      = cnn_pkg::DATA_W,
    parameter int ADDR_W      = cnn_pkg::ADDR_W,
    parameter int WIDTH       = cnn_pkg::WIDTH,
    parameter int HEIGHT      = cnn_pkg::HEIGHT,
    parameter int DEPTH       = WIDTH * HEIGHT,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [7:0]        iByte,
    input  logic              iByteValid,
    output logic              oByteReady,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    output logic              oBusy,
    output logic              oFrameDone,
    output logic              oFrameLoaded
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    cnn_pkg::loader_state_t state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              loaded_q, loaded_d;

    logic                       accept;
    logic                       pix_valid;
    logic [cnn_pkg::DATA_W-1:0] pix_word;

    // iStart wins over a byte offered in the same cycle.
    assign accept = iByteValid && ready_q && !iStart;

    rgb888_byte_packer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_packer (
        .clk_i       (iClk),
        .rst_i       (iRst),
        .clr_i       (iStart),
        .en_i        (state_q == cnn_pkg::ST_LOAD),
        .accept_i    (accept),
        .byte_i      (iByte),
        .pix_valid_o (pix_valid),
        .pix_word_o  (pix_word)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= cnn_pkg::ST_IDLE;
            pix_cnt_q <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            loaded_q  <= loaded_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        last_d    = 1'b0;
        case (state_q)
            cnn_pkg::ST_IDLE: begin
                if (iStart) state_d = cnn_pkg::ST_LOAD;
            end
            cnn_pkg::ST_LOAD: begin
                if (pix_valid) begin
                    // Hold the count at the last address rather than wrapping.
                    if (pix_cnt_q == LAST_ADDR) begin
                        state_d = cnn_pkg::ST_DONE;
                        last_d  = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            cnn_pkg::ST_DONE: begin
                if (iStart) state_d = cnn_pkg::ST_LOAD;
            end
            default: state_d = cnn_pkg::ST_IDLE;
        endcase
        if (iStart) pix_cnt_d = '0;

        ready_d  = (state_d == cnn_pkg::ST_LOAD);
        busy_d   = (state_d == cnn_pkg::ST_LOAD);
        we_d     = pix_valid;
        addr_d   = pix_valid ? pix_cnt_q : addr_q;
        data_d   = pix_valid ? pix_word  : data_q;
        done_d   = last_q;
        loaded_d = iStart ? 1'b0 : (last_q ? 1'b1 : loaded_q);
    end

    assign oByteReady   = ready_q;
    assign oBusy        = busy_q;
    assign oWe          = we_q;
    assign oAddr        = addr_q;
    assign oData        = data_q;
    assign oFrameDone   = done_q;
    assign oFrameLoaded = loaded_q;

endmodule

// File: tb/tb_inbuf_loader.sv
// Bench for inbuf_loader with a 4-pixel frame and an 8-cycle timeout; a byte
// stream model predicts every BRAM write and the frame-done pulse.
module tb_inbuf_loader;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int AW    = 17;
    localparam int DW    = 24;

    logic          iClk = 1'b0;
    logic          iRst, iStart, iByteValid;
    logic [7:0]    iByte;
    logic          oByteReady, oWe, oBusy, oFrameDone, oFrameLoaded;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oData;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        act_q[$];
    wr_t        exp_q[$];
    int         done_q[$];
    logic [7:0] m_part[$];
    int         m_pix;
    int         m_done;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    inbuf_loader #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iByte(iByte),
        .iByteValid(iByteValid), .oByteReady(oByteReady), .oWe(oWe),
        .oAddr(oAddr), .oData(oData), .oBusy(oBusy),
        .oFrameDone(oFrameDone), .oFrameLoaded(oFrameLoaded)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oWe === 1'b1) act_q.push_back({32'(cyc), oAddr, oData});
        if (oFrameDone === 1'b1) done_q.push_back(cyc);
    end

    // Stream model: three accepted bytes form one pixel at the next address;
    // a partial pixel is lost after TO idle cycles or on iStart.
    task automatic model_start();
        m_part.delete();
        m_pix = 0;
    endtask

    task automatic model_gap(input int n);
        if (n >= TO) m_part.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input int acc_cyc);
        m_part.push_back(b);
        if (m_part.size() == 3) begin
            exp_q.push_back({32'(acc_cyc), AW'(m_pix), m_part[0], m_part[1], m_part[2]});
            m_pix++;
            m_part.delete();
            if (m_pix == DEPTH) m_done++;
        end
    endtask

    task automatic clear_logs();
        act_q.delete();
        exp_q.delete();
        done_q.delete();
        m_done = 0;
    endtask

    task automatic start();
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        model_start();
    endtask

    // Idles for gap cycles, then offers b until accepted (bounded).
    task automatic send(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        iByteValid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge iClk);
            #1;
        end
        model_gap(gap);
        iByte = b;
        iByteValid = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge iClk);
            got = oByteReady;
            @(posedge iClk); #1;
        end
        iByteValid = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout byte %h: ready got 0 want 1 within 20 cycles", b);
        end else begin
            model_byte(b, cyc);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1; iStart = 1'b0; iByteValid = 1'b0; iByte = 8'h00;
        repeat (3) @(negedge iClk);
        checks++;
        if ({oByteReady, oWe, oAddr, oData, oBusy, oFrameDone, oFrameLoaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy %b we %b addr %h data %h busy %b done %b loaded %b want all 0",
                     oByteReady, oWe, oAddr, oData, oBusy, oFrameDone, oFrameLoaded);
        end
        @(posedge iClk); #2;
        iRst = 1'b0;
        clear_logs();
        iByteValid = 1'b1; iByte = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checks++;
            if (oByteReady !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready got %b want 0", oByteReady);
            end
        end
        iByteValid = 1'b0;
        checks++;
        if (act_q.size() !== 0) begin
            errors++;
            $display("FAIL idle_writes got %0d want 0", act_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start();
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 0);
        repeat (4) @(posedge iClk); #1;
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_nwrites got %0d want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (done_q.size() !== m_done) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want %0d", done_q.size(), m_done);
        end else if (done_q.size() == 1 && exp_q.size() > 0) begin
            checks++;
            if (done_q[0] !== int'(exp_q[$].cyc) + 1) begin
                errors++;
                $display("FAIL b2b_done_cycle got %0d want %0d", done_q[0], int'(exp_q[$].cyc) + 1);
            end
        end
        checks++;
        if ({oFrameLoaded, oByteReady, oBusy} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_final got loaded %b ready %b busy %b want 1 0 0", oFrameLoaded, oByteReady, oBusy);
        end
    endtask

    task automatic test_done_stall();
        clear_logs();
        iByteValid = 1'b1; iByte = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            checks++;
            if ({oByteReady, oWe, oFrameLoaded} !== 3'b001) begin
                errors++;
                $display("FAIL stall_cycle%0d got ready %b we %b loaded %b want 0 0 1", i, oByteReady, oWe, oFrameLoaded);
            end
        end
        @(posedge iClk); #1;
        iByteValid = 1'b0;
        start();
        @(negedge iClk);
        checks++;
        if ({oFrameLoaded, oByteReady, oBusy} !== 3'b011) begin
            errors++;
            $display("FAIL restart_from_done got loaded %b ready %b busy %b want 0 1 1", oFrameLoaded, oByteReady, oBusy);
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_toggle_gap();
        clear_logs();
        start();
        for (int i = 0; i < 12; i++) send(8'($urandom), (i == 4) ? 5 : (i % 2));
        repeat (4) @(posedge iClk); #1;
        checks++;
        if (act_q.size() !== exp_q.size() || exp_q.size() != DEPTH) begin
            errors++;
            $display("FAIL toggle_nwrites got %0d want %0d", act_q.size(), DEPTH);
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL toggle_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (done_q.size() !== m_done) begin
            errors++;
            $display("FAIL toggle_done_count got %0d want %0d", done_q.size(), m_done);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        start();
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'h01, TO);
        send(8'h02, 0);
        send(8'h03, 0);
        repeat (12) @(posedge iClk); #1;
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL timeout_nwrites got %0d want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if ({done_q.size() != 0, oBusy, oFrameLoaded} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_state got done_pulses %0d busy %b loaded %b want 0 1 0", done_q.size(), oBusy, oFrameLoaded);
        end
    endtask

    task automatic test_restart();
        clear_logs();
        start();
        for (int i = 0; i < 6; i++) send(8'($urandom), 0);
        iByte = 8'hEE; iByteValid = 1'b1; iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0; iByteValid = 1'b0;
        model_start();
        for (int i = 0; i < 12; i++) send(8'($urandom), 0);
        repeat (4) @(posedge iClk); #1;
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL restart_nwrites got %0d want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (done_q.size() !== m_done) begin
            errors++;
            $display("FAIL restart_done_count got %0d want %0d", done_q.size(), m_done);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            clear_logs();
            start();
            for (int n = 0; n < 200 && m_pix < DEPTH; n++)
                send(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 0);
            repeat (4) @(posedge iClk); #1;
            checks++;
            if (act_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_nwrites got %0d want %0d", f, act_q.size(), exp_q.size());
            end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                             f, i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                end
            end
            checks++;
            if (done_q.size() !== m_done || oFrameLoaded !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_done got pulses %0d loaded %b want %0d 1", f, done_q.size(), oFrameLoaded, m_done);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        start();
        send(8'h5A, 0);
        send(8'hA5, 0);
        #3;
        iRst = 1'b1;
        #1;
        checks++;
        if ({oByteReady, oWe, oAddr, oData, oBusy, oFrameDone, oFrameLoaded} !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy %b we %b addr %h data %h busy %b done %b loaded %b want all 0",
                     oByteReady, oWe, oAddr, oData, oBusy, oFrameDone, oFrameLoaded);
        end
        repeat (2) @(posedge iClk);
        #2;
        iRst = 1'b0;
        @(posedge iClk); #1;
        clear_logs();
        start();
        for (int i = 0; i < 12; i++) send(8'($urandom), 0);
        repeat (4) @(posedge iClk); #1;
        checks++;
        if (act_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL post_reset_nwrites got %0d want %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL post_reset_write%0d got cyc %0d addr %0d data %h want cyc %0d addr %0d data %h",
                         i, act_q[i].cyc, act_q[i].addr, act_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (done_q.size() !== m_done) begin
            errors++;
            $display("FAIL post_reset_done_count got %0d want %0d", done_q.size(), m_done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        m_pix = 0;
        m_done = 0;
        test_reset();
        test_back_to_back();
        test_done_stall();
        test_toggle_gap();
        test_timeout();
        test_restart();
        test_random_frames();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inbuf_loader.md
Name: inbuf_loader

Overview:
- Writer side of the input image BRAM.
- Accepts a byte stream (R, G, B per pixel, raster order), packs each 3 bytes into one RGB888 word and writes it to inbuf_wrapper port A at sequential addresses 0..DEPTH-1.
- Signals frame completion so the 3x3 window reader can start.
- Sits between the host/UART byte receiver and the input memory.

Parameters:
- DATA_W, 24, pixel word width, {R[23:16],G[15:8],B[7:0]}
- ADDR_W, 17, BRAM address width
- WIDTH, 480, image width in pixels
- HEIGHT, 272, image height in pixels
- DEPTH, WIDTH*HEIGHT, pixels per frame; must satisfy DEPTH <= 2^ADDR_W
- TIMEOUT_CYC, 100000, idle cycles after which a partial pixel is discarded; 0 disables the timeout

Ports:
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle pulse; arms or restarts a frame load
- iByte  in  8  stream byte
- iByteValid  in  1  iByte is valid this cycle
- oByteReady  out  1  loader accepts a byte this cycle
- oWe  out  1  BRAM write enable (one cycle per pixel)
- oAddr  out  ADDR_W  BRAM write address
- oData  out  DATA_W  BRAM write data
- oBusy  out  1  high while in LOAD
- oFrameDone  out  1  one-cycle pulse after the last pixel write
- oFrameLoaded  out  1  level; high from frame completion until the next iStart

Behaviour:
- Reset (async, iRst=1): state=IDLE, byte count=0, pixel count=0, timeout count=0. All outputs 0: oByteReady, oWe, oAddr, oData, oBusy, oFrameDone, oFrameLoaded.
- FSM states IDLE, LOAD, DONE. All outputs are registered.
- IDLE: oByteReady=0. iStart -> LOAD with byte count and pixel count cleared.
- LOAD:
  - oByteReady=1 and oBusy=1.
  - A byte is accepted when iByteValid && oByteReady.
  - Byte index 0 -> R, 1 -> G, 2 -> B. The byte count wraps 2 -> 0.
- Pixel write:
  - On acceptance of byte index 2, the next cycle drives oWe=1, oAddr=pixel count and oData={R,G,B}.
  - Pixel count then increments. Latency is exactly 1 cycle from the B-byte acceptance to oWe.
  - oWe is 0 on all other cycles; oAddr and oData hold their last values.
- Last pixel:
  - When the B byte of pixel DEPTH-1 is accepted, oByteReady falls in the next cycle, the same cycle as that oWe.
  - State becomes DONE.
  - oFrameDone=1 for exactly the cycle after the last oWe; oFrameLoaded=1 from that same cycle.
- DONE: oByteReady=0 and oBusy=0. Incoming bytes are not accepted (upstream stalls). iStart -> LOAD with counters cleared and oFrameLoaded=0 on the next cycle.
- iStart while in LOAD:
  - Restarts the frame: counters are cleared, any partial pixel is discarded and the next accepted byte is R of address 0.
  - A write already scheduled for this cycle still completes.
- iStart coinciding with byte acceptance: iStart wins and the byte is dropped.
- Timeout:
  - While in LOAD with byte count != 0, a counter increments on every cycle without acceptance and resets on acceptance.
  - When it reaches TIMEOUT_CYC, byte count -> 0 (partial pixel discarded); the pixel count is unchanged.
  - Inactive when TIMEOUT_CYC=0.
- Pixel count and oAddr never exceed DEPTH-1; there is no wrap within a frame.
- Reset mid-frame aborts immediately. Partially written BRAM contents are undefined; no oFrameDone is produced.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W, ADDR_W, WIDTH, HEIGHT, DEPTH
  - the loader state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - RGB888 field offsets
- One sub-module, rgb888_byte_packer:
  - contains the byte counter, R/G registers and the timeout counter
  - outputs a pixel-valid strobe plus the packed word
  - also has a synchronous-clear input driven by iStart
- The top of inbuf_loader holds the FSM and the address counter.

Test Plan (DEPTH=4, TIMEOUT_CYC=8 for sim):
- Reset, then iStart, then 12 back-to-back bytes 0x10..0x1B -> oWe pulses at addr 0..3 with data 0x101112, 0x131415, 0x161718, 0x191A1B. Each oWe comes 1 cycle after its B byte; oFrameDone pulses once; oFrameLoaded=1; oByteReady=0.
- Valid toggling every other cycle plus a 5-cycle gap mid-pixel -> same 4 words written; no timeout fires (gap < 8).
- Send 2 bytes 0xAA, 0xBB, then idle 8 cycles, then 3 bytes 0x01, 0x02, 0x03 -> write addr 0 data 0x010203; nothing written for 0xAA/0xBB.
- Load 2 pixels, iStart, then 12 new bytes -> writes restart at addr 0; exactly 4 writes after the restart; a single oFrameDone.
- In DONE, hold iByteValid=1 for 10 cycles -> oByteReady=0 and no oWe. Then iStart -> oFrameLoaded=0 next cycle and oByteReady=1.
- Assert iRst asynchronously mid-pixel (between clock edges) -> all outputs 0 immediately. After release plus iStart, a full frame loads correctly from addr 0.
